ets_sweep_ctrl: RTL and testbench
=================================

# ets_sweep_ctrl

Sequencer that drives the equivalent-time-sampling (ETS) phase-offset clock generator through a sweep of delay settings. At each setting it waits for the generator to settle and report lock, then runs one capture with the downstream sample-capture engine. The block sits between the host/control registers and the ETS clock generator. It owns the generator's `delay` input and consumes its `lock` output, so that a full equivalent-time waveform is built from one capture per phase step.

## Interface

Parameters:
- `DELAY_WIDTH`, 8: width of the delay code sent to the clock generator.
- `SETTLE_CYCLES`, 16: cycles ignored after each delay change, before `lock` is examined. Minimum 1.
- `LOCK_STABLE`, 4: number of consecutive cycles `lock` must be high before a capture is issued. Minimum 1.
- `LOCK_TIMEOUT`, 4096: maximum cycles spent waiting for stable lock after settling, before the sweep aborts.

Ports (one clock; reset is synchronous and active-low):
- `clk` input 1: single system clock; the same domain as the clock generator's control side.
- `rst_n` input 1: synchronous, active-low reset.
- `start` input 1: one-cycle pulse that begins a sweep. Ignored while `busy`.
- `first_delay` input DELAY_WIDTH: delay code of the first step. Sampled on `start`.
- `last_delay` input DELAY_WIDTH: inclusive upper bound of the sweep. Sampled on `start`.
- `step_size` input DELAY_WIDTH: delay increment per step. Sampled on `start`; a value of 0 is treated as 1.
- `delay` output DELAY_WIDTH: delay code driven to the clock generator.
- `lock` input 1: lock indication from the clock generator. Treated as synchronous to `clk`.
- `capture_req` output 1: request for one capture at the current delay.
- `capture_ack` input 1: the capture engine has finished the requested capture.
- `step_index` output DELAY_WIDTH: zero-based index of the current step, for tagging captured data.
- `busy` output 1: high from the cycle after `start` until the sweep ends.
- `done` output 1: one-cycle pulse when a sweep completes normally.
- `error` output 1: sticky lock-timeout flag. Cleared by the next accepted `start` or by reset.

## Operation

- The FSM has six states: IDLE, SETTLE, WAIT_LOCK, CAPTURE, ADVANCE, FINISH.
- IDLE, with `start` high: latch `first_delay`, `last_delay` and `step_size` (0 becomes 1); load `delay` with `first_delay`; clear `step_index` and `error`; go to SETTLE.
- If `first_delay` > `last_delay`: exactly one step is still run at `first_delay`, then FINISH.
- SETTLE: count SETTLE_CYCLES cycles regardless of `lock`, then go to WAIT_LOCK. Clear the stability counter and the timeout counter on entry.
- WAIT_LOCK, each cycle:
  - If `lock` is high, increment the stability counter; otherwise clear it.
  - When the stability counter reaches LOCK_STABLE, go to CAPTURE.
  - The timeout counter increments every cycle. When it reaches LOCK_TIMEOUT without stable lock: set `error`, go to IDLE, and drop `busy`. No `done` pulse is issued.
- CAPTURE: hold `capture_req` high until a cycle in which `capture_ack` is high, then go to ADVANCE.
  - `capture_ack` is ignored in every state except CAPTURE.
  - A loss of `lock` during CAPTURE is ignored; the capture engine owns data validity.
- ADVANCE: compute `sum = delay + step` at DELAY_WIDTH+1 bits.
  - If the carry bit is set, or `sum[DELAY_WIDTH-1:0]` > `last_delay`, go to FINISH.
  - Otherwise load `delay` with `sum`, increment `step_index`, and go to SETTLE.
  - A step exactly equal to `last_delay` is captured.
- FINISH: pulse `done` for one cycle, then go to IDLE.
- `delay` holds its last value in IDLE. It changes only on accepted `start` or in ADVANCE.
- `step_index` wraps modulo 2^DELAY_WIDTH. No wrap is possible when the step is at least 1 and the carry rule above applies.

## Timing

- Reset values: state IDLE, `delay` 0, `step_index` 0, `capture_req` 0, `busy` 0, `done` 0, `error` 0.
- A reset asserted in any state, including mid-capture, returns all outputs to these values on the next edge. `capture_req` drops without waiting for `capture_ack`.
- All outputs are registered.
- Sequence from `start` at edge 0:
  - At edge 1: `busy` = 1 and `delay` = `first_delay`.
  - SETTLE occupies edges 1..SETTLE_CYCLES.
  - With `lock` held high throughout, `capture_req` rises SETTLE_CYCLES + LOCK_STABLE cycles after `busy` rises.
- `capture_ack` sampled high at edge N:
  - `capture_req` is low at edge N+1 (ADVANCE).
  - The new `delay` is visible at edge N+1 if the sweep continues.
  - On the last step, `done` = 1 at edge N+2 and `busy` = 0 at edge N+3.
- `capture_req` is never high in the same cycle that `delay` changes.
- `start` during `busy` has no effect, including in the FINISH cycle.

## Test plan

- **Basic sweep.** Parameters SETTLE_CYCLES=4, LOCK_STABLE=2. Inputs: `first_delay`=0, `last_delay`=6, `step_size`=2, `lock` tied high, `capture_ack` returned 3 cycles after each `capture_req`. Required: exactly 4 captures at `delay` 0, 2, 4, 6 with `step_index` 0..3, one `done` pulse, `error`=0.
- **Wrap guard.** Inputs: `first_delay`=250, `last_delay`=255, `step_size`=4. Required: captures at 250 and 254 only; the carry from 254+4 ends the sweep with `done`.
- **Lock glitch.** Drop `lock` for 1 cycle after 1 high cycle in WAIT_LOCK. Required: the stability count restarts, and `capture_req` is delayed by the glitch length plus LOCK_STABLE.
- **Timeout.** LOCK_TIMEOUT=32, `lock` tied low. Required: `error`=1 and `busy`=0 exactly 32 cycles after WAIT_LOCK is entered; no `done`, no `capture_req`. A new `start` then clears `error`.
- **Reset mid-capture.** Assert `rst_n`=0 while `capture_req`=1. Required: next edge gives `capture_req`=0, `delay`=0, `busy`=0. A later `capture_ack` is ignored.
- **Edge inputs.** Case 1: `step_size`=0, `first_delay`=3, `last_delay`=5. Required: captures at 3, 4 and 5. Case 2: `first_delay`=9 > `last_delay`=5. Required: a single capture at 9, then `done`.

Source files
------------

// File: rtl/ets_sweep_ctrl.sv
// ETS sweep sequencer: steps the phase-offset generator's delay code, waits for
// settle and stable lock, then runs one capture per step.
module ets_sweep_ctrl #(
  parameter int unsigned DELAY_WIDTH   = 8,
  parameter int unsigned SETTLE_CYCLES = 16,
  parameter int unsigned LOCK_STABLE   = 4,
  parameter int unsigned LOCK_TIMEOUT  = 4096
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [DELAY_WIDTH-1:0] first_delay,
  input  logic [DELAY_WIDTH-1:0] last_delay,
  input  logic [DELAY_WIDTH-1:0] step_size,
  output logic [DELAY_WIDTH-1:0] delay,
  input  logic                   lock,
  output logic                   capture_req,
  input  logic                   capture_ack,
  output logic [DELAY_WIDTH-1:0] step_index,
  output logic                   busy,
  output logic                   done,
  output logic                   error
);

  localparam int unsigned SW = $clog2(SETTLE_CYCLES + 1);
  localparam int unsigned LW = $clog2(LOCK_STABLE + 1);
  localparam int unsigned TW = $clog2(LOCK_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SETTLE, S_WAIT_LOCK, S_CAPTURE, S_ADVANCE, S_FINISH
  } state_t;

  state_t state, state_n;

  logic [SW-1:0]          settle_cnt;
  logic [LW-1:0]          stab_cnt;
  logic [TW-1:0]          tmo_cnt;
  logic [DELAY_WIDTH-1:0] last_q;
  logic [DELAY_WIDTH-1:0] step_q;
  logic                   last_step;
  logic [DELAY_WIDTH:0]   sum;
  logic                   sweep_more;
  logic                   settle_hit;
  logic                   stab_hit;
  logic                   tmo_hit;

  always_comb begin
    sum        = {1'b0, delay} + {1'b0, step_q};
    sweep_more = !sum[DELAY_WIDTH] && (sum[DELAY_WIDTH-1:0] <= last_q);
    settle_hit = (settle_cnt == SW'(SETTLE_CYCLES - 1));
    stab_hit   = lock && (stab_cnt == LW'(LOCK_STABLE - 1));
    tmo_hit    = (tmo_cnt == TW'(LOCK_TIMEOUT - 1));
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:      if (start) state_n = S_SETTLE;
      S_SETTLE:    if (settle_hit) state_n = S_WAIT_LOCK;
      S_WAIT_LOCK: begin
        if (stab_hit)     state_n = S_CAPTURE;
        else if (tmo_hit) state_n = S_IDLE;
      end
      S_CAPTURE:   if (capture_ack) state_n = S_ADVANCE;
      S_ADVANCE:   state_n = last_step ? S_FINISH : S_SETTLE;
      S_FINISH:    state_n = S_IDLE;
      default:     state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      delay       <= '0;
      step_index  <= '0;
      capture_req <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
      settle_cnt  <= '0;
      stab_cnt    <= '0;
      tmo_cnt     <= '0;
      last_q      <= '0;
      step_q      <= '0;
      last_step   <= 1'b0;
    end else begin
      state       <= state_n;
      busy        <= (state_n != S_IDLE);
      capture_req <= (state_n == S_CAPTURE);
      done        <= (state_n == S_FINISH);
      case (state)
        S_IDLE: if (start) begin
          last_q     <= last_delay;
          step_q     <= (step_size == '0) ? DELAY_WIDTH'(1) : step_size;
          delay      <= first_delay;
          step_index <= '0;
          error      <= 1'b0;
          settle_cnt <= '0;
        end
        S_SETTLE: begin
          settle_cnt <= settle_cnt + 1'b1;
          stab_cnt   <= '0;
          tmo_cnt    <= '0;
        end
        S_WAIT_LOCK: begin
          stab_cnt <= lock ? stab_cnt + 1'b1 : '0;
          tmo_cnt  <= tmo_cnt + 1'b1;
          if (tmo_hit && !stab_hit) error <= 1'b0 | 1'b1;
        end
        // The step decision is taken on the ack edge so the new delay is
        // already on the generator during the ADVANCE cycle.
        S_CAPTURE: if (capture_ack) begin
          last_step <= !sweep_more;
          if (sweep_more) begin
            delay      <= sum[DELAY_WIDTH-1:0];
            step_index <= step_index + 1'b1;
          end
        end
        S_ADVANCE: settle_cnt <= '0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ets_sweep_ctrl.sv
// Scoreboard bench for ets_sweep_ctrl: expected captures/done pulses are queued
// by the stimulus and popped by an independent monitor.
module tb_ets_sweep_ctrl;

  localparam int unsigned S = 4;
  localparam int unsigned L = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       lock = 1'b0;
  logic       capture_ack = 1'b0;
  logic [7:0] first_delay = '0;
  logic [7:0] last_delay = '0;
  logic [7:0] step_size = '0;
  logic [7:0] delay;
  logic [7:0] step_index;
  logic       capture_req;
  logic       busy;
  logic       done;
  logic       error;

  always #5 clk = ~clk;

  ets_sweep_ctrl #(
    .DELAY_WIDTH(8),
    .SETTLE_CYCLES(S),
    .LOCK_STABLE(L),
    .LOCK_TIMEOUT(32)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .first_delay(first_delay), .last_delay(last_delay), .step_size(step_size),
    .delay(delay), .lock(lock), .capture_req(capture_req), .capture_ack(capture_ack),
    .step_index(step_index), .busy(busy), .done(done), .error(error)
  );

  typedef struct {
    bit         is_done;
    logic [7:0] d;
    logic [7:0] idx;
  } ev_t;

  ev_t exp_q[$];
  int  errors = 0;
  int  checks = 0;
  bit  ack_en = 1'b1;
  logic req_q = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  task automatic push_cap(input logic [7:0] d, input logic [7:0] idx);
    ev_t e;
    e.is_done = 1'b0; e.d = d; e.idx = idx;
    exp_q.push_back(e);
  endtask

  task automatic push_done();
    ev_t e;
    e.is_done = 1'b1; e.d = '0; e.idx = '0;
    exp_q.push_back(e);
  endtask

  // Monitor: one event per capture_req rise and per done pulse
  always @(negedge clk) begin
    ev_t e;
    if (rst_n) begin
      if (capture_req && !req_q) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_capture: got delay %0d idx %0d required none", delay, step_index);
        end else begin
          e = exp_q.pop_front();
          check("cap_kind", {31'd0, e.is_done}, 32'd0);
          check("cap_delay", {24'd0, delay}, {24'd0, e.d});
          check("cap_index", {24'd0, step_index}, {24'd0, e.idx});
        end
      end
      if (done) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done: got done=1 required none");
        end else begin
          e = exp_q.pop_front();
          check("done_kind", {31'd0, e.is_done}, 32'd1);
        end
      end
    end
    req_q = capture_req;
  end

  // Capture engine: ack sampled 3 cycles after capture_req first appears
  initial forever begin
    @(negedge clk);
    if (ack_en && capture_req) begin
      repeat (2) @(posedge clk);
      #1 capture_ack = 1'b1;
      @(posedge clk);
      #1 capture_ack = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish required finish");
    $fatal(1, "watchdog");
  end

  task automatic do_start(input logic [7:0] f, input logic [7:0] l, input logic [7:0] s);
    @(posedge clk);
    #1;
    first_delay = f; last_delay = l; step_size = s; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy !== 1'b0 && n < 1000) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 1000) begin
      checks++; errors++;
      $display("FAIL %s_timeout: got busy=%b required 0", name, busy);
    end
    repeat (2) @(posedge clk);
    #1 check({name, "_queue_empty"}, exp_q.size(), 32'd0);
  endtask

  task automatic req_latency(input string name, input int k0, input int exp_k);
    int k = k0;
    while (capture_req !== 1'b1 && k < 200) begin
      @(posedge clk); #1; k++;
    end
    check(name, k, exp_k);
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_delay", {24'd0, delay}, 32'd0);
    check("rst_index", {24'd0, step_index}, 32'd0);
    check("rst_req", {31'd0, capture_req}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_error", {31'd0, error}, 32'd0);
    rst_n = 1'b1;
    lock = 1'b1;

    // Basic sweep 0..6 step 2
    push_cap(8'd0, 8'd0); push_cap(8'd2, 8'd1); push_cap(8'd4, 8'd2); push_cap(8'd6, 8'd3); push_done();
    do_start(8'd0, 8'd6, 8'd2);
    check("basic_busy_edge1", {31'd0, busy}, 32'd1);
    req_latency("basic_req_latency", 0, S + L);
    wait_idle("basic");
    check("basic_error", {31'd0, error}, 32'd0);

    // Wrap guard: 254+4 carries
    push_cap(8'd250, 8'd0); push_cap(8'd254, 8'd1); push_done();
    do_start(8'd250, 8'd255, 8'd4);
    check("wrap_delay_edge1", {24'd0, delay}, 32'd250);
    wait_idle("wrap");

    // step_size 0 behaves as 1
    push_cap(8'd3, 8'd0); push_cap(8'd4, 8'd1); push_cap(8'd5, 8'd2); push_done();
    do_start(8'd3, 8'd5, 8'd0);
    wait_idle("step0");

    // first > last: single step
    push_cap(8'd9, 8'd0); push_done();
    do_start(8'd9, 8'd5, 8'd3);
    wait_idle("inverted");

    // Lock glitch: high at first WAIT_LOCK sample, low at the next
    push_cap(8'd10, 8'd0); push_done();
    do_start(8'd10, 8'd10, 8'd1);
    repeat (5) @(posedge clk);
    #1 lock = 1'b0;
    @(posedge clk);
    #1 lock = 1'b1;
    req_latency("glitch_req_latency", 6, 8);
    wait_idle("glitch");

    // Timeout with lock low: WAIT_LOCK seen from edge 5, abort seen at edge 37
    lock = 1'b0;
    do_start(8'd20, 8'd30, 8'd5);
    repeat (35) @(posedge clk);
    #1;
    check("tmo_busy_before", {31'd0, busy}, 32'd1);
    check("tmo_error_before", {31'd0, error}, 32'd0);
    @(posedge clk);
    #1;
    check("tmo_error", {31'd0, error}, 32'd1);
    check("tmo_busy", {31'd0, busy}, 32'd0);
    repeat (3) @(posedge clk);
    #1 check("tmo_error_sticky", {31'd0, error}, 32'd1);
    lock = 1'b1;
    push_cap(8'd20, 8'd0); push_done();
    do_start(8'd20, 8'd20, 8'd1);
    check("restart_clears_error", {31'd0, error}, 32'd0);
    wait_idle("restart");

    // Reset mid-capture
    ack_en = 1'b0;
    push_cap(8'd40, 8'd0);
    do_start(8'd40, 8'd50, 8'd5);
    req_latency("rstcap_req_latency", 0, S + L);
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("rstcap_req", {31'd0, capture_req}, 32'd0);
    check("rstcap_delay", {24'd0, delay}, 32'd0);
    check("rstcap_busy", {31'd0, busy}, 32'd0);
    check("rstcap_index", {24'd0, step_index}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1 capture_ack = 1'b1;
    @(posedge clk);
    #1 capture_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("late_ack_busy", {31'd0, busy}, 32'd0);
    check("late_ack_req", {31'd0, capture_req}, 32'd0);
    check("late_ack_delay", {24'd0, delay}, 32'd0);
    check("final_queue_empty", exp_q.size(), 32'd0);
    ack_en = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
